// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_pkg
// Description : Shared constants, helper functions and operand class encoding
//               for the parametrizable binary floating-point blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_pkg;

    // Operand classification
    typedef enum logic [2:0] {
        FP_ZERO      = 3'd0,
        FP_SUBNORMAL = 3'd1,
        FP_NORMAL    = 3'd2,
        FP_INF       = 3'd3,
        FP_NAN       = 3'd4
    } fp_class_e;

    // Exponent bias: 2^(ew-1) - 1
    function automatic logic [63:0] fp_bias(input int unsigned ew);
        return (64'd1 << (ew - 1)) - 64'd1;
    endfunction

    // Exponent field with every bit set (Inf/NaN encoding)
    function automatic logic [63:0] fp_exp_ones(input int unsigned ew);
        return (64'd1 << ew) - 64'd1;
    endfunction

    // Canonical quiet NaN with sign bit clear: exp all ones, fraction MSB set
    function automatic logic [63:0] fp_qnan(input int unsigned ew, input int unsigned mw);
        return (fp_exp_ones(ew) << mw) | (64'd1 << (mw - 1));
    endfunction

endpackage : fp_pkg
`default_nettype wire

// File: rtl/fp_round_normalize.sv
`default_nettype none
// ============================================================================
// Module      : fp_round_normalize
// Description : Normalizes a raw significand product, rounds it to nearest
//               even and range-checks the resulting biased exponent. Results
//               below the normal range flush to zero; results at or above the
//               all-ones exponent saturate to infinity.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_round_normalize
    import fp_pkg::*;
#(
    parameter int EXPONENT_WIDTH = 8,
    parameter int MANTISSA_WIDTH = 23,
    parameter int EXP_CALC_WIDTH = 11
) (
    input  logic [2*(MANTISSA_WIDTH+1)-1:0] prod_i,
    input  logic signed [EXP_CALC_WIDTH-1:0] exp_i,
    output logic [EXPONENT_WIDTH-1:0]       exp_o,
    output logic [MANTISSA_WIDTH-1:0]       frac_o,
    output logic                            overflow_o,
    output logic                            underflow_o
);

    localparam int c_SIG_W  = MANTISSA_WIDTH + 1;
    localparam int c_PROD_W = 2 * c_SIG_W;
    localparam int c_LZ_W   = $clog2(c_PROD_W) + 1;

    localparam logic [63:0] c_EXP_ONES_64 = fp_exp_ones(EXPONENT_WIDTH);
    localparam logic [EXPONENT_WIDTH-1:0] c_EXP_ONES = c_EXP_ONES_64[EXPONENT_WIDTH-1:0];
    localparam logic signed [EXP_CALC_WIDTH-1:0] c_EXP_ONES_S =
        $signed(c_EXP_ONES_64[EXP_CALC_WIDTH-1:0]);
    localparam logic signed [EXP_CALC_WIDTH-1:0] c_ONE_S =
        $signed(EXP_CALC_WIDTH'(1));

    logic [c_LZ_W-1:0]                 w_lz;
    logic [c_PROD_W-1:0]               w_norm;
    logic signed [EXP_CALC_WIDTH-1:0]  w_lz_s;
    logic signed [EXP_CALC_WIDTH-1:0]  w_exp_norm;
    logic signed [EXP_CALC_WIDTH-1:0]  w_exp_fin;
    logic [MANTISSA_WIDTH-1:0]         w_mant;
    logic                              w_guard;
    logic                              w_sticky;
    logic                              w_round_up;
    logic [c_SIG_W:0]                  w_sig_rnd;
    logic                              w_carry;

    // Leading-zero count: the highest set bit wins because it is visited last
    always_comb begin
        w_lz = '0;
        for (int i = 0; i < c_PROD_W; i++) begin
            if (prod_i[i]) begin
                w_lz = c_LZ_W'(c_PROD_W - 1 - i);
            end
        end
    end

    // Product carries 2*MW fraction bits, so a leading one in the top bit
    // means the value is in [2,4) and the exponent rises by one.
    assign w_norm     = prod_i << w_lz;
    assign w_lz_s     = $signed(EXP_CALC_WIDTH'(w_lz));
    assign w_exp_norm = exp_i + c_ONE_S - w_lz_s;

    assign w_mant     = w_norm[c_PROD_W-2 -: MANTISSA_WIDTH];
    assign w_guard    = w_norm[MANTISSA_WIDTH];
    assign w_sticky   = |w_norm[MANTISSA_WIDTH-1:0];
    assign w_round_up = w_guard & (w_sticky | w_mant[0]);

    // Round-up carry out of 1.111..1 leaves a zero fraction and bumps the exponent
    assign w_sig_rnd  = {2'b01, w_mant} + (c_SIG_W + 1)'(w_round_up);
    assign w_carry    = w_sig_rnd[c_SIG_W];
    assign w_exp_fin  = w_exp_norm + $signed(EXP_CALC_WIDTH'(w_carry));

    // Range check on the final biased exponent and saturation/flush of result
    always_comb begin
        overflow_o  = (w_exp_fin >= c_EXP_ONES_S);
        underflow_o = (w_exp_fin <  c_ONE_S);
        exp_o       = w_exp_fin[EXPONENT_WIDTH-1:0];
        frac_o      = w_sig_rnd[MANTISSA_WIDTH-1:0];
        if (overflow_o) begin
            exp_o  = c_EXP_ONES;
            frac_o = '0;
        end else if (underflow_o) begin
            exp_o  = '0;
            frac_o = '0;
        end
    end

endmodule : fp_round_normalize
`default_nettype wire

// File: rtl/floating_point_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : floating_point_multiplier
// Description : Parametrizable binary floating-point multiplier, out = a * b,
//               round-to-nearest-even, no subnormal outputs. Classification
//               and special cases are resolved here; the finite datapath is
//               normalized and rounded in fp_round_normalize. One output
//               register stage, one-cycle latency, no backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module floating_point_multiplier
    import fp_pkg::*;
#(
    parameter int ExponentWidth = 8,
    parameter int MantissaWidth = 23,
    localparam int FloatBitWidth = ExponentWidth + MantissaWidth + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [FloatBitWidth-1:0] a,
    input  logic [FloatBitWidth-1:0] b,
    output logic                     out_valid,
    output logic [FloatBitWidth-1:0] out,
    output logic                     underflow_flag,
    output logic                     overflow_flag,
    output logic                     invalid_operation_flag
);

    localparam int c_SIG_W  = MantissaWidth + 1;
    localparam int c_PROD_W = 2 * c_SIG_W;
    // Signed exponent width: room for ea+eb and for subtracting a full-width
    // leading-zero count without wrapping.
    localparam int c_EXP_W  = ((ExponentWidth > $clog2(c_PROD_W)) ?
                               ExponentWidth : $clog2(c_PROD_W)) + 3;

    localparam logic [63:0] c_EXP_ONES_64 = fp_exp_ones(ExponentWidth);
    localparam logic [63:0] c_BIAS_64     = fp_bias(ExponentWidth);
    localparam logic [63:0] c_QNAN_64     = fp_qnan(ExponentWidth, MantissaWidth);
    localparam logic [ExponentWidth-1:0] c_EXP_ONES = c_EXP_ONES_64[ExponentWidth-1:0];
    localparam logic [FloatBitWidth-2:0] c_QNAN_MAG = c_QNAN_64[FloatBitWidth-2:0];
    localparam logic signed [c_EXP_W-1:0] c_BIAS_S  = $signed(c_BIAS_64[c_EXP_W-1:0]);

    // Operand classification from the exponent/fraction fields
    function automatic fp_class_e classify(input logic [ExponentWidth-1:0] e,
                                           input logic [MantissaWidth-1:0] f);
        if (e == '0) begin
            return (f == '0) ? FP_ZERO : FP_SUBNORMAL;
        end else if (e == c_EXP_ONES) begin
            return (f == '0) ? FP_INF : FP_NAN;
        end
        return FP_NORMAL;
    endfunction

    logic                      w_sign_a;
    logic                      w_sign_b;
    logic [ExponentWidth-1:0]  w_exp_a;
    logic [ExponentWidth-1:0]  w_exp_b;
    logic [MantissaWidth-1:0]  w_frac_a;
    logic [MantissaWidth-1:0]  w_frac_b;
    fp_class_e                 w_cls_a;
    fp_class_e                 w_cls_b;
    logic [c_SIG_W-1:0]        w_sig_a;
    logic [c_SIG_W-1:0]        w_sig_b;
    logic [ExponentWidth-1:0]  w_exp_eff_a;
    logic [ExponentWidth-1:0]  w_exp_eff_b;
    logic [c_PROD_W-1:0]       w_prod;
    logic signed [c_EXP_W-1:0] w_exp_sum;
    logic                      w_sign_res;

    logic [ExponentWidth-1:0]  w_rn_exp;
    logic [MantissaWidth-1:0]  w_rn_frac;
    logic                      w_rn_ovf;
    logic                      w_rn_unf;

    logic [FloatBitWidth-1:0]  w_res;
    logic                      w_res_unf;
    logic                      w_res_ovf;
    logic                      w_res_inv;

    logic [FloatBitWidth-1:0]  out_d, out_q;
    logic                      out_valid_d, out_valid_q;
    logic                      unf_d, unf_q;
    logic                      ovf_d, ovf_q;
    logic                      inv_d, inv_q;

    assign {w_sign_a, w_exp_a, w_frac_a} = a;
    assign {w_sign_b, w_exp_b, w_frac_b} = b;
    assign w_cls_a    = classify(w_exp_a, w_frac_a);
    assign w_cls_b    = classify(w_exp_b, w_frac_b);
    assign w_sign_res = w_sign_a ^ w_sign_b;

    // Hidden bit is 1 only for normals; subnormals use effective exponent 1
    assign w_sig_a     = {(w_cls_a == FP_NORMAL), w_frac_a};
    assign w_sig_b     = {(w_cls_b == FP_NORMAL), w_frac_b};
    assign w_exp_eff_a = (w_cls_a == FP_SUBNORMAL) ? ExponentWidth'(1) : w_exp_a;
    assign w_exp_eff_b = (w_cls_b == FP_SUBNORMAL) ? ExponentWidth'(1) : w_exp_b;

    assign w_prod    = c_PROD_W'(w_sig_a) * c_PROD_W'(w_sig_b);
    assign w_exp_sum = $signed(c_EXP_W'(w_exp_eff_a)) + $signed(c_EXP_W'(w_exp_eff_b))
                     - c_BIAS_S;

    fp_round_normalize #(
        .EXPONENT_WIDTH (ExponentWidth),
        .MANTISSA_WIDTH (MantissaWidth),
        .EXP_CALC_WIDTH (c_EXP_W)
    ) u_round_normalize (
        .prod_i      (w_prod),
        .exp_i       (w_exp_sum),
        .exp_o       (w_rn_exp),
        .frac_o      (w_rn_frac),
        .overflow_o  (w_rn_ovf),
        .underflow_o (w_rn_unf)
    );

    // Special-case resolution in priority order, then the finite result
    always_comb begin
        w_res     = {w_sign_res, w_rn_exp, w_rn_frac};
        w_res_unf = w_rn_unf;
        w_res_ovf = w_rn_ovf;
        w_res_inv = 1'b0;
        if (w_cls_a == FP_NAN || w_cls_b == FP_NAN) begin
            w_res     = {(w_cls_a == FP_NAN) ? w_sign_a : w_sign_b, c_QNAN_MAG};
            w_res_unf = 1'b0;
            w_res_ovf = 1'b0;
            w_res_inv = 1'b1;
        end else if ((w_cls_a == FP_INF && w_cls_b == FP_ZERO) ||
                     (w_cls_a == FP_ZERO && w_cls_b == FP_INF)) begin
            w_res     = {w_sign_res, c_QNAN_MAG};
            w_res_unf = 1'b0;
            w_res_ovf = 1'b0;
            w_res_inv = 1'b1;
        end else if (w_cls_a == FP_INF || w_cls_b == FP_INF) begin
            w_res     = {w_sign_res, c_EXP_ONES, {MantissaWidth{1'b0}}};
            w_res_unf = 1'b0;
            w_res_ovf = 1'b1;
        end else if (w_cls_a == FP_ZERO || w_cls_b == FP_ZERO) begin
            w_res     = {w_sign_res, {(FloatBitWidth-1){1'b0}}};
            w_res_unf = 1'b0;
            w_res_ovf = 1'b0;
        end
    end

    // Next state: capture a new result on in_valid, otherwise hold
    always_comb begin
        out_valid_d = in_valid;
        out_d       = out_q;
        unf_d       = unf_q;
        ovf_d       = ovf_q;
        inv_d       = inv_q;
        if (in_valid) begin
            out_d = w_res;
            unf_d = w_res_unf;
            ovf_d = w_res_ovf;
            inv_d = w_res_inv;
        end
    end

    // Output register stage with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            unf_q       <= 1'b0;
            ovf_q       <= 1'b0;
            inv_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            unf_q       <= unf_d;
            ovf_q       <= ovf_d;
            inv_q       <= inv_d;
        end
    end

    assign out_valid              = out_valid_q;
    assign out                    = out_q;
    assign underflow_flag         = unf_q;
    assign overflow_flag          = ovf_q;
    assign invalid_operation_flag = inv_q;

endmodule : floating_point_multiplier
`default_nettype wire

// File: tb/tb_floating_point_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_floating_point_multiplier
// Description : Directed-vector bench for the binary32 multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_floating_point_multiplier;

    localparam int c_N = 17;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic [31:0] out;
    logic        underflow_flag;
    logic        overflow_flag;
    logic        invalid_operation_flag;

    int n_vec;
    int n_bad;

    // Operand A, operand B, expected product, expected {underflow, overflow, invalid}
    logic [31:0] va [0:c_N-1] = '{
        32'h40400000, 32'h410B3333, 32'h469C4600, 32'h38D1B717,
        32'h00000001, 32'h7F7FFFFF, 32'h7F800000, 32'hFF800000,
        32'hFF800000, 32'hFFC00000, 32'hFFA00000, 32'h7F800000,
        32'h00000000, 32'h3F800000, 32'h00800000, 32'h40000000,
        32'hC0000000};
    logic [31:0] vb [0:c_N-1] = '{
        32'h40800000, 32'h3E99999A, 32'h3DCCCCCD, 32'h3F6E147B,
        32'h00000001, 32'h40000000, 32'h40400000, 32'h7F800000,
        32'hFF800000, 32'h40800000, 32'h00000000, 32'h00000000,
        32'h40400000, 32'h3F800000, 32'h3F000000, 32'h7FC00000,
        32'h40400000};
    logic [31:0] ve [0:c_N-1] = '{
        32'h41400000, 32'h40270A3E, 32'h44FA099A, 32'h38C308FE,
        32'h00000000, 32'h7F800000, 32'h7F800000, 32'hFF800000,
        32'h7F800000, 32'hFFC00000, 32'hFFC00000, 32'h7FC00000,
        32'h00000000, 32'h3F800000, 32'h00000000, 32'h7FC00000,
        32'hC0C00000};
    logic [2:0]  vf [0:c_N-1] = '{
        3'b000, 3'b000, 3'b000, 3'b000,
        3'b100, 3'b010, 3'b010, 3'b010,
        3'b010, 3'b001, 3'b001, 3'b001,
        3'b000, 3'b000, 3'b100, 3'b001,
        3'b000};

    floating_point_multiplier #(
        .ExponentWidth (8),
        .MantissaWidth (23)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .in_valid               (in_valid),
        .a                      (a),
        .b                      (b),
        .out_valid              (out_valid),
        .out                    (out),
        .underflow_flag         (underflow_flag),
        .overflow_flag          (overflow_flag),
        .invalid_operation_flag (invalid_operation_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [31:0] o,
                           input logic [2:0] f);
        chk({tag, " valid"}, 64'(out_valid), 64'(v));
        chk({tag, " out"},   64'(out), 64'(o));
        chk({tag, " flags"},
            64'({underflow_flag, overflow_flag, invalid_operation_flag}), 64'(f));
    endtask

    initial begin
        n_vec    = 0;
        n_bad    = 0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk_all("reset async", 1'b0, 32'h0, 3'b000);
        repeat (2) @(posedge clk);
        #1 chk_all("reset held", 1'b0, 32'h0, 3'b000);
        @(negedge clk) rst_n = 1'b1;

        // Back-to-back vectors, one per cycle
        for (int i = 0; i < c_N; i++) begin
            @(negedge clk);
            a        = va[i];
            b        = vb[i];
            in_valid = 1'b1;
            @(posedge clk);
            #1 chk_all($sformatf("vec%0d %h*%h", i, va[i], vb[i]), 1'b1, ve[i], vf[i]);
        end

        // Idle cycle: valid drops, result and flags hold
        @(negedge clk);
        in_valid = 1'b0;
        a        = 32'h3F800000;
        b        = 32'h3F800000;
        @(posedge clk);
        #1 chk_all("idle hold", 1'b0, ve[c_N-1], vf[c_N-1]);

        // Overflow result then hold keeps the overflow flag
        @(negedge clk);
        a        = 32'h7F7FFFFF;
        b        = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk);
        #1 chk_all("ovf again", 1'b1, 32'h7F800000, 3'b010);
        @(negedge clk) in_valid = 1'b0;
        @(posedge clk);
        #1 chk_all("ovf hold", 1'b0, 32'h7F800000, 3'b010);

        // Reset asserted mid-stream clears immediately
        @(negedge clk);
        a        = 32'h40400000;
        b        = 32'h40800000;
        in_valid = 1'b1;
        @(posedge clk);
        #1 chk_all("pre-reset", 1'b1, 32'h41400000, 3'b000);
        @(negedge clk);
        a        = 32'h7F800000;
        b        = 32'h00000000;
        #2 rst_n = 1'b0;
        #1 chk_all("mid reset", 1'b0, 32'h0, 3'b000);
        @(posedge clk);
        #1 chk_all("mid reset edge", 1'b0, 32'h0, 3'b000);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 chk_all("post reset", 1'b1, 32'h7FC00000, 3'b001);
        @(negedge clk) in_valid = 1'b0;
        @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_floating_point_multiplier
`default_nettype wire
